// File: rtl/eth_pump_mux.sv
// eth_pump_mux: frame-granular round-robin aggregator of NUM_CH AXI-Stream
// Ethernet sources into one stream. Each frame is prefixed by a header beat
// carrying the source channel index. Frames longer than MAX_LEN payload beats
// are truncated (tuser set) and their remainder is drained upstream.
module eth_pump_mux #(
   parameter int NUM_CH  = 4,
   parameter int DATA_W  = 8,
   parameter int MAX_LEN = 1522,
   parameter int CNT_W   = 32
) (
   input  logic                     iclk_eth,
   input  logic                     irst_eth,
   input  logic [NUM_CH-1:0]        cfg_ch_en,
   input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
   input  logic [NUM_CH-1:0]        s_axis_tvalid,
   output logic [NUM_CH-1:0]        s_axis_tready,
   input  logic [NUM_CH-1:0]        s_axis_tlast,
   input  logic [NUM_CH-1:0]        s_axis_tuser,
   output logic [DATA_W-1:0]        m_axis_tdata,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output logic                     m_axis_tuser,
   output logic [CNT_W-1:0]         stat_frames,
   output logic [CNT_W-1:0]         stat_trunc,
   output logic [CNT_W-1:0]         stat_bad,
   output logic                     busy
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   typedef enum logic [1:0] {IDLE, HDR, DATA, DROP} state_t;

   state_t              state;
   logic [CH_W-1:0]     gnt;
   logic [CH_W-1:0]     ptr;
   logic [CH_W-1:0]     pick;
   logic                found;
   logic [LEN_W-1:0]    len;
   logic                load;
   logic                in_hs;
   logic [DATA_W-1:0]   in_data;
   logic                in_valid;
   logic                in_last;
   logic                in_user;

   // Status counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // The output register can take a new beat when empty or being drained.
   assign load     = !m_axis_tvalid || m_axis_tready;
   assign in_data  = s_axis_tdata[gnt*DATA_W +: DATA_W];
   assign in_valid = s_axis_tvalid[gnt];
   assign in_last  = s_axis_tlast[gnt];
   assign in_user  = s_axis_tuser[gnt];
   assign in_hs    = in_valid && s_axis_tready[gnt];
   assign busy     = (state != IDLE);

   // Only the granted channel sees ready: paced by the output in DATA, free-running in DROP.
   always_comb begin
      s_axis_tready = '0;
      if (state == DATA)
         s_axis_tready[gnt] = load;
      else if (state == DROP)
         s_axis_tready[gnt] = 1'b1;
   end

   // Round-robin search for the first enabled requester starting at ptr.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found && s_axis_tvalid[(int'(ptr) + i) % NUM_CH]
                    && cfg_ch_en[(int'(ptr) + i) % NUM_CH]) begin
            found = 1'b1;
            pick  = CH_W'((int'(ptr) + i) % NUM_CH);
         end
      end
   end

   // Frame FSM with the single output register and status counters.
   always_ff @(posedge iclk_eth or negedge irst_eth) begin
      if (!irst_eth) begin
         state         <= IDLE;
         gnt           <= '0;
         ptr           <= '0;
         len           <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         stat_frames   <= '0;
         stat_trunc    <= '0;
         stat_bad      <= '0;
      end else begin
         // A beat accepted downstream empties the register unless refilled below.
         if (m_axis_tready)
            m_axis_tvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  gnt   <= pick;
                  ptr   <= (pick == CH_W'(NUM_CH - 1)) ? '0 : pick + CH_W'(1);
                  state <= HDR;
               end
            end
            HDR: begin
               if (load) begin
                  m_axis_tdata  <= {{(DATA_W - CH_W){1'b0}}, gnt};
                  m_axis_tvalid <= 1'b1;
                  m_axis_tlast  <= 1'b0;
                  m_axis_tuser  <= 1'b0;
                  len           <= '0;
                  state         <= DATA;
               end
            end
            DATA: begin
               if (in_hs) begin
                  m_axis_tdata  <= in_data;
                  m_axis_tvalid <= 1'b1;
                  len           <= len + LEN_W'(1);
                  if (in_last) begin
                     m_axis_tlast <= 1'b1;
                     m_axis_tuser <= in_user;
                     stat_frames  <= sat_inc(stat_frames);
                     if (in_user)
                        stat_bad <= sat_inc(stat_bad);
                     state <= IDLE;
                  end else if (len == LEN_W'(MAX_LEN - 1)) begin
                     m_axis_tlast <= 1'b1;
                     m_axis_tuser <= 1'b1;
                     stat_frames  <= sat_inc(stat_frames);
                     stat_trunc   <= sat_inc(stat_trunc);
                     state        <= DROP;
                  end else begin
                     m_axis_tlast <= 1'b0;
                     m_axis_tuser <= 1'b0;
                  end
               end
            end
            DROP: begin
               if (in_valid && in_last)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_pump_mux.sv
// Directed bench for eth_pump_mux (NUM_CH=4, DATA_W=8, MAX_LEN=8).
// Per-channel source queues feed the inputs; every accepted output beat is
// logged as {data, last, user} and compared against hand-computed vectors.
module tb_eth_pump_mux;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  cfg_ch_en = 4'hF;
   logic [31:0] s_tdata = '0;
   logic [3:0]  s_tvalid = '0;
   logic [3:0]  s_tready;
   logic [3:0]  s_tlast = '0;
   logic [3:0]  s_tuser = '0;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b1;
   logic        m_tlast;
   logic        m_tuser;
   logic [31:0] stat_frames;
   logic [31:0] stat_trunc;
   logic [31:0] stat_bad;
   logic        busy;

   int errors = 0;
   int checks = 0;

   logic [9:0]  src_q [4][$];
   logic [9:0]  out_q [$];
   logic [9:0]  drv_hd;
   logic [3:0]  hs_s = '0;
   int          rdy_cnt [4];
   int          hs_cnt3 = 0;
   logic        bp_en = 1'b0;
   logic [3:0]  bp_pat = 4'b1001;
   int          bp_idx = 0;
   int          viol = 0;
   logic        pv = 1'b0;
   logic        pr = 1'b0;
   logic [7:0]  pd = '0;

   eth_pump_mux #(.NUM_CH(4), .DATA_W(8), .MAX_LEN(8), .CNT_W(32)) dut (
      .iclk_eth(clk), .irst_eth(rst_n), .cfg_ch_en(cfg_ch_en),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
      .stat_frames(stat_frames), .stat_trunc(stat_trunc), .stat_bad(stat_bad),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Source model: pop accepted beats after the edge and present the next queued beat.
   always begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         if (hs_s[k] && src_q[k].size() > 0)
            void'(src_q[k].pop_front());
         if (src_q[k].size() > 0) begin
            drv_hd            = src_q[k][0];
            s_tvalid[k]       = 1'b1;
            s_tdata[k*8 +: 8] = drv_hd[9:2];
            s_tlast[k]        = drv_hd[1];
            s_tuser[k]        = drv_hd[0];
         end else begin
            s_tvalid[k]       = 1'b0;
            s_tdata[k*8 +: 8] = 8'h00;
            s_tlast[k]        = 1'b0;
            s_tuser[k]        = 1'b0;
         end
      end
      hs_s = '0;
      if (bp_en) begin
         m_tready = bp_pat[bp_idx];
         bp_idx   = (bp_idx + 1) % 4;
      end
   end

   // Monitor: sample handshakes just before each rising edge.
   always begin
      @(negedge clk);
      #4;
      hs_s = s_tvalid & s_tready;
      for (int k = 0; k < 4; k++)
         if (s_tready[k]) rdy_cnt[k]++;
      if (hs_s[3]) hs_cnt3++;
      if (m_tvalid && m_tready)
         out_q.push_back({m_tdata, m_tlast, m_tuser});
      if (bp_en) begin
         if (s_tready[1] && m_tvalid && !m_tready) viol++;
         if ((s_tready & 4'b1101) != 4'b0000) viol++;
         if (pv && !pr && (!m_tvalid || m_tdata !== pd)) viol++;
         pv = m_tvalid;
         pr = m_tready;
         pd = m_tdata;
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      for (int k = 0; k < 4; k++) src_q[k].delete();
      hs_s = '0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      out_q.delete();
      for (int k = 0; k < 4; k++) rdy_cnt[k] = 0;
      hs_cnt3 = 0;
      @(posedge clk);
   endtask

   task automatic test_reset();
      #3;
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_tvalid); end
      checks++; if ({m_tlast, m_tuser} !== 2'b00) begin errors++; $display("FAIL reset_last_user got %b want 00", {m_tlast, m_tuser}); end
      checks++; if (m_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata got %h want 00", m_tdata); end
      checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL reset_s_tready got %b want 0000", s_tready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if ((stat_frames | stat_trunc | stat_bad) !== 32'd0) begin errors++; $display("FAIL reset_stats got %0d/%0d/%0d want 0", stat_frames, stat_trunc, stat_bad); end
      do_reset();
      repeat (3) @(posedge clk);
      #2;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
   endtask

   task automatic test_single();
      logic [9:0] e [5];
      do_reset();
      cfg_ch_en = 4'hF;
      m_tready  = 1'b1;
      src_q[2].push_back({8'h11, 2'b00});
      src_q[2].push_back({8'h22, 2'b00});
      src_q[2].push_back({8'h33, 2'b00});
      src_q[2].push_back({8'h44, 2'b10});
      e[0] = {8'h02, 2'b00}; e[1] = {8'h11, 2'b00}; e[2] = {8'h22, 2'b00};
      e[3] = {8'h33, 2'b00}; e[4] = {8'h44, 2'b10};
      for (int i = 0; i < 100 && out_q.size() < 5; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #2;
      checks++; if (out_q.size() !== 5) begin errors++; $display("FAIL single_count got %0d want 5", out_q.size()); end
      for (int i = 0; i < 5 && i < out_q.size(); i++) begin
         checks++; if (out_q[i] !== e[i]) begin errors++; $display("FAIL single_beat%0d got %h want %h", i, out_q[i], e[i]); end
      end
      checks++; if (stat_frames !== 32'd1) begin errors++; $display("FAIL single_frames got %0d want 1", stat_frames); end
      checks++; if (rdy_cnt[2] !== 4) begin errors++; $display("FAIL single_ready_cycles got %0d want 4", rdy_cnt[2]); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", busy); end
   endtask

   task automatic test_round_robin();
      int ord [6];
      logic [9:0] e;
      int ch;
      int f;
      ord = '{0, 1, 3, 0, 1, 3};
      do_reset();
      for (int fr = 0; fr < 2; fr++) begin
         for (int k = 0; k < 4; k++) begin
            if (k != 2) begin
               src_q[k].push_back({8'(k*16 + fr*2 + 1), 2'b00});
               src_q[k].push_back({8'(k*16 + fr*2 + 2), 2'b10});
            end
         end
      end
      for (int i = 0; i < 300 && out_q.size() < 18; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #2;
      checks++; if (out_q.size() !== 18) begin errors++; $display("FAIL rr_count got %0d want 18", out_q.size()); end
      for (int j = 0; j < 6; j++) begin
         ch = ord[j];
         f  = j / 3;
         for (int b = 0; b < 3; b++) begin
            if (b == 0)      e = {8'(ch), 2'b00};
            else if (b == 1) e = {8'(ch*16 + f*2 + 1), 2'b00};
            else             e = {8'(ch*16 + f*2 + 2), 2'b10};
            if (j*3 + b < out_q.size()) begin
               checks++; if (out_q[j*3 + b] !== e) begin errors++; $display("FAIL rr_frame%0d_beat%0d got %h want %h", j, b, out_q[j*3 + b], e); end
            end
         end
      end
      checks++; if (stat_frames !== 32'd6) begin errors++; $display("FAIL rr_frames got %0d want 6", stat_frames); end
   endtask

   task automatic test_truncate();
      logic [9:0] e;
      do_reset();
      for (int i = 1; i <= 12; i++) src_q[1].push_back({8'(i), (i == 12), 1'b0});
      for (int i = 0; i < 200 && (out_q.size() < 9 || src_q[1].size() > 0); i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #2;
      checks++; if (out_q.size() !== 9) begin errors++; $display("FAIL trunc_count got %0d want 9", out_q.size()); end
      for (int i = 0; i < 9 && i < out_q.size(); i++) begin
         e = (i == 0) ? {8'h01, 2'b00} : {8'(i), (i == 8), (i == 8)};
         checks++; if (out_q[i] !== e) begin errors++; $display("FAIL trunc_beat%0d got %h want %h", i, out_q[i], e); end
      end
      checks++; if (src_q[1].size() !== 0) begin errors++; $display("FAIL trunc_drain got %0d left want 0", src_q[1].size()); end
      checks++; if (stat_trunc !== 32'd1) begin errors++; $display("FAIL trunc_stat got %0d want 1", stat_trunc); end
      checks++; if (stat_frames !== 32'd1) begin errors++; $display("FAIL trunc_frames got %0d want 1", stat_frames); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL trunc_busy got %b want 0", busy); end
      out_q.delete();
      for (int i = 1; i <= 8; i++) src_q[1].push_back({8'(8'h40 + i), (i == 8), 1'b0});
      for (int i = 0; i < 200 && out_q.size() < 9; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #2;
      checks++; if (out_q.size() !== 9) begin errors++; $display("FAIL exact_count got %0d want 9", out_q.size()); end
      if (out_q.size() >= 9) begin
         checks++; if (out_q[8] !== {8'h48, 2'b10}) begin errors++; $display("FAIL exact_last got %h want %h", out_q[8], {8'h48, 2'b10}); end
      end
      checks++; if (stat_trunc !== 32'd1) begin errors++; $display("FAIL exact_trunc got %0d want 1", stat_trunc); end
      checks++; if (stat_frames !== 32'd2) begin errors++; $display("FAIL exact_frames got %0d want 2", stat_frames); end
   endtask

   task automatic test_backpressure();
      logic [9:0] e;
      do_reset();
      viol   = 0;
      pv     = 1'b0;
      bp_idx = 0;
      bp_en  = 1'b1;
      for (int i = 1; i <= 6; i++) src_q[1].push_back({8'(8'hA0 + i), (i == 6), 1'b0});
      for (int i = 0; i < 200 && out_q.size() < 7; i++) @(posedge clk);
      repeat (4) @(posedge clk);
      #2;
      bp_en    = 1'b0;
      m_tready = 1'b1;
      checks++; if (out_q.size() !== 7) begin errors++; $display("FAIL bp_count got %0d want 7", out_q.size()); end
      for (int i = 0; i < 7 && i < out_q.size(); i++) begin
         e = (i == 0) ? {8'h01, 2'b00} : {8'(8'hA0 + i), (i == 6), 1'b0};
         checks++; if (out_q[i] !== e) begin errors++; $display("FAIL bp_beat%0d got %h want %h", i, out_q[i], e); end
      end
      checks++; if (viol !== 0) begin errors++; $display("FAIL bp_stall_rules got %0d violations want 0", viol); end
      checks++; if (rdy_cnt[1] !== 6) begin errors++; $display("FAIL bp_ready_cycles got %0d want 6", rdy_cnt[1]); end
   endtask

   task automatic test_mask_bad();
      logic [9:0] e [3];
      do_reset();
      cfg_ch_en = 4'b1011;
      src_q[2].push_back({8'h21, 2'b00});
      src_q[2].push_back({8'h22, 2'b10});
      repeat (10) @(posedge clk);
      #2;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mask_busy got %b want 0", busy); end
      checks++; if (out_q.size() !== 0) begin errors++; $display("FAIL mask_out got %0d beats want 0", out_q.size()); end
      checks++; if (src_q[2].size() !== 2) begin errors++; $display("FAIL mask_consumed got %0d left want 2", src_q[2].size()); end
      src_q[2].delete();
      src_q[0].push_back({8'h55, 2'b00});
      src_q[0].push_back({8'h66, 2'b11});
      e[0] = {8'h00, 2'b00}; e[1] = {8'h55, 2'b00}; e[2] = {8'h66, 2'b11};
      for (int i = 0; i < 100 && out_q.size() < 3; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #2;
      checks++; if (out_q.size() !== 3) begin errors++; $display("FAIL bad_count got %0d want 3", out_q.size()); end
      for (int i = 0; i < 3 && i < out_q.size(); i++) begin
         checks++; if (out_q[i] !== e[i]) begin errors++; $display("FAIL bad_beat%0d got %h want %h", i, out_q[i], e[i]); end
      end
      checks++; if (stat_bad !== 32'd1) begin errors++; $display("FAIL bad_stat got %0d want 1", stat_bad); end
      checks++; if (stat_frames !== 32'd1) begin errors++; $display("FAIL bad_frames got %0d want 1", stat_frames); end
      cfg_ch_en = 4'hF;
   endtask

   task automatic test_reset_mid();
      logic [9:0] e [3];
      do_reset();
      src_q[0].push_back({8'h77, 2'b10});
      for (int i = 0; i < 100 && out_q.size() < 2; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #2;
      checks++; if (stat_frames !== 32'd1) begin errors++; $display("FAIL rmid_pre_frames got %0d want 1", stat_frames); end
      for (int i = 1; i <= 6; i++) src_q[3].push_back({8'(8'hC0 + i), (i == 6), 1'b0});
      for (int i = 0; i < 100 && hs_cnt3 < 2; i++) @(posedge clk);
      #2;
      checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got %b want 1", m_tvalid); end
      rst_n = 1'b0;
      #1;
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_tvalid got %b want 0", m_tvalid); end
      checks++; if (stat_frames !== 32'd0) begin errors++; $display("FAIL rmid_frames got %0d want 0", stat_frames); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
      checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL rmid_s_tready got %b want 0000", s_tready); end
      for (int k = 0; k < 4; k++) src_q[k].delete();
      hs_s = '0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      out_q.delete();
      @(posedge clk);
      src_q[3].push_back({8'h91, 2'b00});
      src_q[3].push_back({8'h92, 2'b10});
      e[0] = {8'h03, 2'b00}; e[1] = {8'h91, 2'b00}; e[2] = {8'h92, 2'b10};
      for (int i = 0; i < 100 && out_q.size() < 3; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #2;
      checks++; if (out_q.size() !== 3) begin errors++; $display("FAIL rmid_post_count got %0d want 3", out_q.size()); end
      for (int i = 0; i < 3 && i < out_q.size(); i++) begin
         checks++; if (out_q[i] !== e[i]) begin errors++; $display("FAIL rmid_post_beat%0d got %h want %h", i, out_q[i], e[i]); end
      end
      checks++; if (stat_frames !== 32'd1) begin errors++; $display("FAIL rmid_post_frames got %0d want 1", stat_frames); end
   endtask

   initial begin
      for (int k = 0; k < 4; k++) rdy_cnt[k] = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_truncate();
      test_backpressure();
      test_mask_bad();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/eth_pump_mux.md
Name: eth_pump_mux

Overview:
- Frame-granular N-channel aggregator for the modem TX path. Merges NUM_CH AXI-Stream Ethernet-frame sources (GMII-RX/FIFO outputs) into one modem-bound stream.
- Each frame is prefixed with one header beat carrying the channel index, so the far-end demux can route it.
- Enforces a maximum frame length by truncation and keeps status counters.
- Sits between the per-port frame FIFOs and the COBS encoder, all in the Ethernet clock domain.

Parameters:
NUM_CH, 4, number of input channels (2..16)
DATA_W, 8, tdata width of inputs and output (>= 8)
MAX_LEN, 1522, maximum payload beats per frame before forced truncation (>= 2)
CNT_W, 32, width of status counters

Ports:
iclk_eth  input  1  clock, all logic rising edge
irst_eth  input  1  reset, asynchronous assert, active-low
cfg_ch_en  input  NUM_CH  per-channel enable mask; disabled channels are never granted
s_axis_tdata  input  NUM_CH*DATA_W  channel payload, channel k at bits [k*DATA_W +: DATA_W]
s_axis_tvalid  input  NUM_CH  per-channel valid
s_axis_tready  output  NUM_CH  per-channel ready
s_axis_tlast  input  NUM_CH  per-channel end of frame
s_axis_tuser  input  NUM_CH  per-channel bad-frame flag, qualified with tlast
m_axis_tdata  output  DATA_W  merged stream data
m_axis_tvalid  output  1  merged valid
m_axis_tready  input  1  downstream ready
m_axis_tlast  output  1  end of merged frame
m_axis_tuser  output  1  bad/truncated frame flag, on tlast beat only
stat_frames  output  CNT_W  frames completed on output
stat_trunc  output  CNT_W  frames truncated at MAX_LEN
stat_bad  output  CNT_W  frames forwarded with input tuser=1
busy  output  1  high when not in IDLE

Behaviour:
- Reset (irst_eth=0, async): state IDLE; all s_axis_tready=0; m_axis_tvalid/tlast/tuser=0; m_axis_tdata=0; counters=0; rr pointer=0; busy=0.
- Output stage is one register. Define load = !m_axis_tvalid || m_axis_tready. A beat is loaded only when load=1. m_axis_tvalid holds with stable data until accepted.
- States: IDLE, HDR, DATA, DROP.
- IDLE: requests are req[k] = s_axis_tvalid[k] & cfg_ch_en[k]. Round-robin search starts at ptr, which is the last granted channel +1, mod NUM_CH. The first requester is granted: latch gnt and set ptr=gnt+1. Go to HDR. No input beat is consumed in IDLE.
- HDR: when load, emit header beat with tdata = gnt zero-extended to DATA_W, tlast=0, tuser=0. Clear payload counter len=0. Go to DATA.
- DATA: s_axis_tready[gnt] = load; all other readies are 0. On an input handshake, forward the beat into the output register and increment len.
  - Input tlast: output tlast=1, tuser=input tuser. Increment stat_frames; increment stat_bad if tuser. Go to IDLE.
  - Otherwise, if len reaches MAX_LEN (the accepted beat is the MAX_LEN-th): output tlast=1, tuser=1. Increment stat_frames and stat_trunc. Go to DROP.
- DROP: s_axis_tready[gnt]=1 regardless of output. Input beats are discarded. On input tlast, go to IDLE.
- Frame atomicity: once granted, the grant is held until the input tlast (or until the DROP ends). A deassert of cfg_ch_en mid-frame does not abort the frame. cfg_ch_en is sampled only in IDLE.
- Latency: grant in cycle t, header valid at t+1, first payload at t+2 if downstream is ready. Back-to-back frames cost 1 idle cycle (IDLE) plus 1 header beat.
- Header and payload bubbles: input tvalid low in DATA inserts no output beat. The output register may then go invalid.
- A frame with tlast on its first beat is legal: output is header + 1 beat.
- A tlast on exactly the MAX_LEN-th beat counts as a normal completion, not a truncation.
- Counters saturate at all-ones. No wrap.
- stat_* update in the cycle the tlast beat enters the output register.
- Reset mid-frame: everything returns to reset values immediately. A partial frame is lost with no tlast emitted. Upstream must be reset together.

Test Plan:
1. Single channel: ch2 sends a 4-beat frame 11,22,33,44 (last on 44), m_axis_tready=1 -> output 02,11,22,33,44, tlast on 44, tuser=0; stat_frames=1; ch2 tready high 4 cycles.
2. Round-robin: ch0, ch1 and ch3 valid continuously with 2-beat frames -> header order 00,01,03,00,01,03; no interleaving inside a frame.
3. Truncation: MAX_LEN=8, ch1 sends 12 beats -> output header + 8 beats, tlast+tuser on the 8th. Input beats 9..12 accepted and dropped. stat_trunc=1, stat_frames=1. Also: exactly 8 beats with tlast -> no truncation.
4. Backpressure: m_axis_tready toggled 1,0,0,1 repeatedly during a 6-beat frame -> output data stable while stalled, no beat lost or duplicated, s_axis_tready mirrors load.
5. Enable mask/bad frame: cfg_ch_en=4'b1011 with ch2 valid only -> no grant, busy=0. ch0 frame with tuser=1 on last -> output tuser=1, stat_bad=1.
6. Reset mid-frame: assert irst_eth low during beat 3 of a frame -> tvalid=0 and counters=0 asynchronously. After release, a new frame gets a fresh header.
